// File: rtl/ram64_pkg.sv
// Shared sizing constants and word/address types for the 8x16 two-read, one-write register-file RAM.
package ram64_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/ram64_rd_port.sv
// One registered read port: word mux plus an output register that clears on reset.
// Define WR_BYPASS_EN for write-first forwarding on a same-address collision.
module ram64_rd_port
  import ram64_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem [DEPTH],
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out
);

  word_t d_out_d;
  word_t d_out_q;

`ifdef WR_BYPASS_EN
  always_comb begin
    d_out_d = mem[rd_addr];
    // On a collision, forward the incoming word so it is visible on this edge.
    if (wr && (wr_addr == rd_addr)) begin
      d_out_d = d_in;
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr, wr_addr, d_in};

  // Without forwarding, a collision returns the old word because mem is still pre-write.
  always_comb begin
    d_out_d = mem[rd_addr];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      d_out_q <= '0;
    end else begin
      d_out_q <= d_out_d;
    end
  end

  assign d_out = d_out_q;

endmodule

// File: rtl/ram64_2r1w.sv
// 8x16 register-file RAM with one write port and two registered read ports (A, B).
// Optional WR_BYPASS_EN selects write-first collision behaviour in the read ports.
module ram64_2r1w
  import ram64_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] d_in,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] d_out_a,
  output logic [DATA_W-1:0] d_out_b
);

  word_t mem_q [DEPTH];
  word_t mem_d [DEPTH];

  // Every word is resettable, so storage is flops rather than an inferred RAM.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      always_comb begin
        mem_d[gi] = mem_q[gi];
        if (wr && (wr_addr == addr_t'(gi))) begin
          mem_d[gi] = d_in;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          mem_q[gi] <= '0;
        end else begin
          mem_q[gi] <= mem_d[gi];
        end
      end
    end
  endgenerate

  ram64_rd_port u_rd_a (
    .clk     (clk),
    .reset   (reset),
    .mem     (mem_q),
    .rd_addr (rd_addr_a),
    .wr      (wr),
    .wr_addr (wr_addr),
    .d_in    (d_in),
    .d_out   (d_out_a)
  );

  ram64_rd_port u_rd_b (
    .clk     (clk),
    .reset   (reset),
    .mem     (mem_q),
    .rd_addr (rd_addr_b),
    .wr      (wr),
    .wr_addr (wr_addr),
    .d_in    (d_in),
    .d_out   (d_out_b)
  );

endmodule

// File: tb/tb_ram64_2r1w.sv
// Self-checking bench for ram64_2r1w: directed vector table, then a random phase against a behavioural model.
module tb_ram64_2r1w;
  import ram64_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  logic  wr;
  addr_t wr_addr;
  word_t d_in;
  addr_t rd_addr_a;
  addr_t rd_addr_b;
  word_t d_out_a;
  word_t d_out_b;

  ram64_2r1w dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .wr_addr   (wr_addr),
    .d_in      (d_in),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .d_out_a   (d_out_a),
    .d_out_b   (d_out_b)
  );

  always #5 clk = ~clk;

`ifdef WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic  rst;
    logic  wr;
    addr_t wa;
    word_t din;
    addr_t ra;
    addr_t rb;
    word_t ea;
    word_t eb;
    string name;
  } vec_t;

  typedef struct {
    word_t ea;
    word_t eb;
    string name;
  } exp_t;

  vec_t  vecs[$];
  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_txn    = 0;
  word_t model [DEPTH];

  function automatic void add(input logic r, input logic w, input addr_t wa, input word_t din,
                              input addr_t ra, input addr_t rb, input word_t ea, input word_t eb,
                              input string name);
    vec_t v;
    v.rst = r; v.wr = w; v.wa = wa; v.din = din;
    v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare just after the edge.
  task automatic run_cycle(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset = v.rst; wr = v.wr; wr_addr = v.wa; d_in = v.din;
    rd_addr_a = v.ra; rd_addr_b = v.rb;
    e.ea = v.ea; e.eb = v.eb; e.name = v.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      got = sb.pop_front();
      check({got.name, "_a"}, d_out_a, got.ea);
      check({got.name, "_b"}, d_out_b, got.eb);
      n_txn++;
      $display("txn %0d %s rst=%b wr=%b wa=%0d din=%h ra=%0d rb=%0d -> a=%h b=%h",
               n_txn, got.name, v.rst, v.wr, v.wa, v.din, v.ra, v.rb, d_out_a, d_out_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    vec_t  v;
    word_t coll_a;

    reset = 1'b0; wr = 1'b0; wr_addr = '0; d_in = '0; rd_addr_a = '0; rd_addr_b = '0;
    coll_a = BYPASS ? 16'hBEEF : 16'h0000;

    // Directed table following the test plan.
    add(1, 0, 0, 16'hFFFF, 0, 0, 16'h0000, 16'h0000, "reset");
    for (int i = 0; i < DEPTH; i++) begin
      add(0, 0, 0, 16'hFFFF, addr_t'(i), addr_t'(DEPTH - 1 - i), 16'h0000, 16'h0000, "post_reset_read");
    end
    add(0, 1, 0, 16'hA5A5, 7, 6, 16'h0000, 16'h0000, "write_a5a5");
    add(0, 1, 1, 16'h5A5A, 7, 6, 16'h0000, 16'h0000, "write_5a5a");
    add(0, 0, 0, 16'h0000, 0, 1, 16'hA5A5, 16'h5A5A, "read_back");
    add(0, 1, 0, 16'h1234, 7, 1, 16'h0000, 16'h5A5A, "overwrite");
    add(0, 0, 0, 16'h0000, 0, 1, 16'h1234, 16'h5A5A, "overwrite_read");
    add(0, 1, 2, 16'hBEEF, 2, 5, coll_a,   16'h0000, "collision");
    add(0, 0, 2, 16'h0000, 2, 2, 16'hBEEF, 16'hBEEF, "after_collision");
    add(0, 0, 0, 16'h0000, 1, 1, 16'h5A5A, 16'h5A5A, "same_addr_both");
    add(0, 0, 0, 16'h0000, 0, 1, 16'h1234, 16'h5A5A, "hold_no_write");
    add(1, 1, 3, 16'hCAFE, 0, 1, 16'h0000, 16'h0000, "reset_mid_op");
    add(0, 0, 0, 16'h0000, 3, 0, 16'h0000, 16'h0000, "reset_discard_write");
    add(0, 0, 0, 16'h0000, 1, 2, 16'h0000, 16'h0000, "reset_cleared");

    foreach (vecs[i]) begin
      run_cycle(vecs[i]);
    end

    // Collision on both ports with different old contents, hand-sequenced.
    v = '{0, 1, 4, 16'h1111, 7, 7, 16'h0000, 16'h0000, "seed_4"};
    run_cycle(v);
    v = '{0, 1, 4, 16'h2222, 4, 4, 16'h0000, 16'h0000, "dual_collision"};
    v.ea = BYPASS ? 16'h2222 : 16'h1111;
    v.eb = v.ea;
    run_cycle(v);
    v = '{0, 0, 0, 16'h0000, 4, 0, 16'h2222, 16'h0000, "dual_collision_after"};
    run_cycle(v);

    // Random phase against a behavioural model; memory now holds only word 4.
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    model[4] = 16'h2222;
    for (int n = 0; n < 60; n++) begin
      v.rst  = 1'b0;
      v.wr   = 1'($urandom_range(0, 1));
      v.wa   = addr_t'($urandom_range(0, DEPTH - 1));
      v.din  = word_t'($urandom);
      v.ra   = addr_t'($urandom_range(0, DEPTH - 1));
      v.rb   = (n % 4 == 0) ? v.wa : addr_t'($urandom_range(0, DEPTH - 1));
      v.ea   = (BYPASS && v.wr && v.wa == v.ra) ? v.din : model[v.ra];
      v.eb   = (BYPASS && v.wr && v.wa == v.rb) ? v.din : model[v.rb];
      v.name = "random";
      if (v.wr) model[v.wa] = v.din;
      run_cycle(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
